dunit_reg_dump: RTL and testbench
=================================

DUNIT_REG_DUMP -- requirements
Module: dunit_reg_dump

Interface
REQ-001 Parameter NB_REG, default 32, register data width in bits (multiple of 8).
REQ-002 Parameter NB_ADDR, default 5, register-file address width.
REQ-003 Parameter N_REGS, default 32, number of registers dumped (at most 2**NB_ADDR).
REQ-004 i_clk  input  1  rising-edge clock.
REQ-005 i_reset  input  1  reset, synchronous, active-high.
REQ-006 i_start  input  1  single-cycle dump request from the debug command decoder.
REQ-007 o_dunit_addr  output  NB_ADDR  register address driven to the ID-stage debug read port.
REQ-008 i_dunit_reg  input  NB_REG  combinational register read data returned for o_dunit_addr.
REQ-009 o_tx_data  output  8  byte presented to the UART transmitter.
REQ-010 o_tx_valid  output  1  o_tx_data valid.
REQ-011 i_tx_ready  input  1  transmitter accepts the byte this cycle.
REQ-012 o_cpu_halt  output  1  high while a dump is in progress; the debug unit uses it to clear the pipeline clock enable.
REQ-013 o_busy  output  1  high in any state other than IDLE.
REQ-014 o_done  output  1  single-cycle pulse on dump completion.

Function
REQ-015 The FSM SHALL have four states: IDLE, FETCH, SEND and DONE.
REQ-016 IDLE: on i_start=1, the block SHALL clear the address counter to 0 and go to FETCH next cycle; otherwise it SHALL stay in IDLE.
REQ-017 In FETCH the block SHALL drive o_dunit_addr=addr and load i_dunit_reg into a NB_REG shift register at the clock edge, clear byte_cnt, and go to SEND (one cycle per fetch).
REQ-018 In SEND, o_tx_valid SHALL be 1 and o_tx_data SHALL equal shift_reg[7:0], transmitting least-significant byte first.
REQ-019 o_tx_valid and o_tx_data SHALL remain stable until a cycle with i_tx_ready=1 (transfer); o_tx_valid SHALL NOT depend combinationally on i_tx_ready.
REQ-020 On each transfer the shift register SHALL shift right by 8 and byte_cnt SHALL increment.
REQ-021 A transfer when byte_cnt = NB_REG/8-1 SHALL go to DONE if addr = N_REGS-1; otherwise it SHALL increment addr and go to FETCH.
REQ-022 DONE SHALL assert o_done for exactly one cycle, then go to IDLE.
REQ-023 i_start SHALL be ignored outside IDLE; i_start together with i_reset SHALL be ignored.
REQ-024 o_cpu_halt and o_busy SHALL be 1 in FETCH, SEND and DONE, and 0 in IDLE.
REQ-025 o_dunit_addr SHALL hold addr in every state, so the read port address is stable for the whole word.
REQ-026 Total dump length SHALL be N_REGS*(1+NB_REG/8)+1 cycles from the first FETCH to the end of DONE when i_tx_ready is held at 1 (161 cycles with the defaults).
REQ-027 The address counter SHALL NOT wrap past N_REGS-1; register 0 SHALL be sent as read (no special-casing).

Reset
REQ-028 On i_reset=1 at a clock edge the block SHALL enter IDLE from any state, including mid-word, and SHALL clear addr, byte_cnt and the shift register.
REQ-029 After reset: o_tx_valid=0, o_tx_data=0, o_dunit_addr=0, o_cpu_halt=0, o_busy=0, o_done=0.
REQ-030 A partially sent word SHALL NOT be resumed after reset.

Structure
REQ-031 A shared debug package SHALL hold the state encoding constants (IDLE=2'b00, FETCH=2'b01, SEND=2'b10, DONE=2'b11), NB_BYTE=8 and the UART byte width.
REQ-032 The block SHALL be a single module with one registered FSM and registered datapath; no sub-module is needed.

Verification
REQ-033 Regs r[i]=32'hA0000000+i, i_tx_ready=1, pulse i_start -> 128 bytes starting 00,00,00,A0,01,00,00,A0; o_done pulses at cycle 161; o_cpu_halt is high for those 161 cycles.
REQ-034 i_tx_ready toggled 1-0-1 during register 5 -> each byte is held stable while not ready, with no duplicated or lost byte; the byte stream is identical to REQ-033.
REQ-035 i_start pulsed again mid-dump at register 10 -> ignored; exactly 128 bytes and one o_done pulse.
REQ-036 i_reset asserted during the 2nd byte of register 7 -> next cycle o_tx_valid=0, o_busy=0, o_dunit_addr=0; a later i_start restarts from register 0.
REQ-037 N_REGS=4 build, r3=32'hDEADBEEF -> last four bytes EF,BE,AD,DE, followed by o_done, with o_dunit_addr never exceeding 3.

Source files
------------

// File: rtl/dunit_reg_dump_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package : dunit_reg_dump_pkg                                           |
// | Purpose : Shared debug-unit definitions. Holds the register-dump FSM   |
// |           state encoding, the byte width and the UART byte width.      |
// | Ports   : none (package)                                               |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
package dunit_reg_dump_pkg;

  // State encoding for the register-dump FSM
  localparam logic [1:0] c_st_idle  = 2'b00;
  localparam logic [1:0] c_st_fetch = 2'b01;
  localparam logic [1:0] c_st_send  = 2'b10;
  localparam logic [1:0] c_st_done  = 2'b11;

  // Bits per byte, and width of one UART transmitter word
  localparam int NB_BYTE = 8;
  localparam int NB_UART = 8;

  typedef enum logic [1:0] {
    IDLE  = c_st_idle,
    FETCH = c_st_fetch,
    SEND  = c_st_send,
    DONE  = c_st_done
  } dump_state_t;

endpackage : dunit_reg_dump_pkg
`default_nettype wire

// File: rtl/dunit_reg_dump.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : dunit_reg_dump                                               |
// | Purpose : Streams the CPU register file out over the UART, one byte    |
// |           at a time, least-significant byte of each register first,    |
// |           while holding the CPU halted.                                |
// | Ports   : i_clk, i_reset (sync, active-high)                           |
// |           i_start      - one-cycle dump request                        |
// |           o_dunit_addr - register address to the debug read port       |
// |           i_dunit_reg  - combinational read data for o_dunit_addr      |
// |           o_tx_data / o_tx_valid / i_tx_ready - UART byte handshake    |
// |           o_cpu_halt   - clears pipeline clock enable while dumping    |
// |           o_busy       - FSM not idle                                  |
// |           o_done       - one-cycle pulse when the dump completes       |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module dunit_reg_dump
  import dunit_reg_dump_pkg::*;
#(
  parameter int NB_REG  = 32,
  parameter int NB_ADDR = 5,
  parameter int N_REGS  = 32
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  output logic [NB_ADDR-1:0] o_dunit_addr,
  input  logic [NB_REG-1:0]  i_dunit_reg,
  output logic [NB_UART-1:0] o_tx_data,
  output logic               o_tx_valid,
  input  logic               i_tx_ready,
  output logic               o_cpu_halt,
  output logic               o_busy,
  output logic               o_done
);

  localparam int NB_BYTES = NB_REG / NB_BYTE;
  localparam int NB_CNT   = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;

  localparam logic [NB_ADDR-1:0] c_last_addr = NB_ADDR'(N_REGS - 1);
  localparam logic [NB_CNT-1:0]  c_last_byte = NB_CNT'(NB_BYTES - 1);

  dump_state_t        r_state;
  dump_state_t        w_next_state;
  logic [NB_ADDR-1:0] r_addr;
  logic [NB_CNT-1:0]  r_byte_cnt;
  logic [NB_REG-1:0]  r_shift;

  logic w_xfer;
  logic w_last_byte;
  logic w_last_addr;

  // A transfer only happens while a byte is being offered
  assign w_xfer      = (r_state == SEND) && i_tx_ready;
  assign w_last_byte = (r_byte_cnt == c_last_byte);
  assign w_last_addr = (r_addr == c_last_addr);

  // ---------------------------------------------------------------------
  // State register and datapath
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_byte_cnt <= '0;
      r_shift    <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_addr <= '0;
          end
        end
        FETCH: begin
          r_shift    <= i_dunit_reg;
          r_byte_cnt <= '0;
        end
        SEND: begin
          if (w_xfer) begin
            r_shift    <= r_shift >> NB_BYTE;
            r_byte_cnt <= r_byte_cnt + 1'b1;
            // Address only advances when another register follows, so it
            // never wraps past the last register.
            if (w_last_byte && !w_last_addr) begin
              r_addr <= r_addr + 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_next_state = FETCH;
        end
      end
      FETCH: begin
        w_next_state = SEND;
      end
      SEND: begin
        if (w_xfer && w_last_byte) begin
          w_next_state = w_last_addr ? DONE : FETCH;
        end
      end
      DONE: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Outputs decode only registered state, so o_tx_valid has no
  // combinational path from i_tx_ready.
  assign o_dunit_addr = r_addr;
  assign o_tx_data    = r_shift[NB_UART-1:0];
  assign o_tx_valid   = (r_state == SEND);
  assign o_busy       = (r_state != IDLE);
  assign o_cpu_halt   = (r_state != IDLE);
  assign o_done       = (r_state == DONE);

endmodule : dunit_reg_dump
`default_nettype wire

// File: tb/tb_dunit_reg_dump.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_dunit_reg_dump                                            |
// | Purpose : Self-checking bench for dunit_reg_dump. Expected byte        |
// |           streams are built from the register contents with plain      |
// |           arithmetic; a second instance covers a 4-register build.     |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module tb_dunit_reg_dump;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic        reset, start, tx_ready;
  logic [4:0]  addr;
  logic [31:0] rd;
  logic [7:0]  tx_data;
  logic        tx_valid, halt, busy, done;
  logic [31:0] regs [32];
  assign rd = regs[addr];

  // N_REGS=4 instance
  logic        reset4, start4, tx_ready4;
  logic [4:0]  addr4;
  logic [31:0] rd4;
  logic [7:0]  tx_data4;
  logic        tx_valid4, halt4, busy4, done4;
  logic [31:0] regs4 [32];
  assign rd4 = regs4[addr4];

  dunit_reg_dump #(.NB_REG(32), .NB_ADDR(5), .N_REGS(32)) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start),
    .o_dunit_addr(addr), .i_dunit_reg(rd),
    .o_tx_data(tx_data), .o_tx_valid(tx_valid), .i_tx_ready(tx_ready),
    .o_cpu_halt(halt), .o_busy(busy), .o_done(done)
  );

  dunit_reg_dump #(.NB_REG(32), .NB_ADDR(5), .N_REGS(4)) dut4 (
    .i_clk(clk), .i_reset(reset4), .i_start(start4),
    .o_dunit_addr(addr4), .i_dunit_reg(rd4),
    .o_tx_data(tx_data4), .o_tx_valid(tx_valid4), .i_tx_ready(tx_ready4),
    .o_cpu_halt(halt4), .o_busy(busy4), .o_done(done4)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Full dump on the default instance.
  // mode 0: ready always 1; 1: random ready; 2: ready toggles during register 5
  task automatic run_dump(input int mode, input bit poke_start, input string tag);
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] pend_data;
    int  cyc = 0, halt_n = 0, done_n = 0, done_at = -1, max_addr = 0;
    bit  pend = 0, poked = 0;
    for (int i = 0; i < 32; i++)
      for (int b = 0; b < 4; b++)
        exp_q.push_back(regs[i][8*b +: 8]);

    start = 1'b1; tx_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc < 3000) begin
      cyc++;
      case (mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = ($urandom_range(0, 3) != 0);
        default: tx_ready = (addr == 5) ? ((cyc % 2) == 1) : 1'b1;
      endcase
      if (poke_start && !poked && addr == 10 && tx_valid) begin
        start = 1'b1; poked = 1;
      end else begin
        start = 1'b0;
      end
      if (pend) begin
        check_val({tag, " hold_valid"}, tx_valid, 1);
        check_val({tag, " hold_data"}, tx_data, pend_data);
      end
      if (halt) halt_n++;
      if (int'(addr) > max_addr) max_addr = int'(addr);
      if (tx_valid && tx_ready) got_q.push_back(tx_data);
      pend      = tx_valid && !tx_ready;
      pend_data = tx_data;
      if (done) begin done_n++; done_at = cyc; end
      @(posedge clk); #1;
      if (done_n > 0) break;
    end
    start = 1'b0;

    check_val({tag, " done_pulses"}, done_n, 1);
    check_val({tag, " busy_after"}, busy, 0);
    check_val({tag, " halt_after"}, halt, 0);
    check_val({tag, " halt_cycles"}, halt_n, done_at);
    if (mode == 0) check_val({tag, " done_cycle"}, done_at, 161);
    check_val({tag, " max_addr_ok"}, max_addr <= 31, 1);
    check_val({tag, " byte_count"}, got_q.size(), 128);
    if (got_q.size() == 128)
      for (int k = 0; k < 128; k++)
        if (got_q[k] !== exp_q[k])
          check_val($sformatf("%s byte%0d", tag, k), got_q[k], exp_q[k]);
    // one aggregate comparison so every stream is counted even when clean
    begin
      int bad = 0;
      for (int k = 0; k < got_q.size() && k < 128; k++)
        if (got_q[k] !== exp_q[k]) bad++;
      check_val({tag, " stream_bad_bytes"}, bad, 0);
    end
    if (got_q.size() >= 8 && mode != 1 && regs[0] == 32'hA000_0000) begin
      check_val({tag, " first_byte3"}, got_q[3], 8'hA0);
      check_val({tag, " first_byte4"}, got_q[4], 8'h01);
    end
  endtask

  task automatic reset_mid_word();
    int seen7 = 0, cyc = 0;
    start = 1'b1; tx_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // stop while the second byte of register 7 is on the bus
    while (cyc < 1000) begin
      cyc++;
      if (addr == 7 && tx_valid) begin
        if (seen7 == 1) break;
        seen7++;
      end
      @(posedge clk); #1;
    end
    check_val("rst_reached_r7b1", seen7, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_val("rst_tx_valid", tx_valid, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_addr", addr, 0);
    check_val("rst_halt", halt, 0);
    check_val("rst_tx_data", tx_data, 0);
    check_val("rst_done", done, 0);
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_no_resume", busy, 0);
  endtask

  task automatic run_dump4();
    logic [7:0] got_q[$];
    int cyc = 0, done_n = 0, done_at = -1, last_x = -1, max_addr = 0, bad = 0;
    start4 = 1'b1; tx_ready4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    while (cyc < 500) begin
      cyc++;
      tx_ready4 = ($urandom_range(0, 2) != 0);
      if (int'(addr4) > max_addr) max_addr = int'(addr4);
      if (tx_valid4 && tx_ready4) begin got_q.push_back(tx_data4); last_x = cyc; end
      if (done4) begin done_n++; done_at = cyc; end
      @(posedge clk); #1;
      if (done_n > 0) break;
    end
    check_val("n4 done_pulses", done_n, 1);
    check_val("n4 done_follows", done_at, last_x + 1);
    check_val("n4 max_addr", max_addr, 3);
    check_val("n4 byte_count", got_q.size(), 16);
    if (got_q.size() == 16) begin
      for (int i = 0; i < 4; i++)
        for (int b = 0; b < 4; b++)
          if (got_q[4*i+b] !== regs4[i][8*b +: 8]) bad++;
      check_val("n4 stream_bad_bytes", bad, 0);
      check_val("n4 last0", got_q[12], 8'hEF);
      check_val("n4 last1", got_q[13], 8'hBE);
      check_val("n4 last2", got_q[14], 8'hAD);
      check_val("n4 last3", got_q[15], 8'hDE);
    end
    check_val("n4 busy_after", busy4, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; tx_ready = 1'b0;
    reset4 = 1'b1; start4 = 1'b0; tx_ready4 = 1'b0;
    for (int i = 0; i < 32; i++) begin regs[i] = 32'hA000_0000 + i; regs4[i] = $urandom; end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0; reset4 = 1'b0;

    check_val("reset tx_valid", tx_valid, 0);
    check_val("reset tx_data", tx_data, 0);
    check_val("reset addr", addr, 0);
    check_val("reset halt", halt, 0);
    check_val("reset busy", busy, 0);
    check_val("reset done", done, 0);
    check_val("reset busy4", busy4, 0);

    // start asserted together with reset must be ignored
    reset = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    check_val("start_with_reset busy", busy, 0);

    run_dump(0, 1'b0, "basic");
    run_dump(2, 1'b0, "toggle_r5");
    run_dump(0, 1'b1, "start_mid");

    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    run_dump(1, 1'b0, "rand_a");
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    run_dump(1, 1'b1, "rand_b");

    for (int i = 0; i < 32; i++) regs[i] = 32'hA000_0000 + i;
    reset_mid_word();
    run_dump(0, 1'b0, "after_reset");

    regs4[3] = 32'hDEAD_BEEF;
    run_dump4();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_dunit_reg_dump
`default_nettype wire
